instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Instruction fetch stage: owns the program counter, issues word reads to instruction memory over a req/ready handshake, and presents one instruction plus its PC+4 per cycle to the IF/ID pipeline register. It honours the hazard unit's `stall` and the branch/jump redirect (`pc_src`/`pc_target`). It inserts a NOP (all-zero word) whenever no valid instruction is available, so the IF/ID register needs no valid bit.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard-unit hold. The same signal is delivered to IF/ID.
- `pc_src` in 1: redirect request, taken branch or jump.
- `pc_target` in 32: redirect address, valid while `pc_src` = 1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word address of the request.
- `imem_ready` in 1: response handshake. Data is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `pc_next_out` out 32: PC+4 of the presented instruction. Drives IF/ID `pc_next_in`.
- `instruction_out` out 32: presented instruction. Drives IF/ID `instruction_in`.
- `fetch_valid` out 1: presented instruction is real, not an inserted NOP.
- `misalign_err` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- **Registers**
  - `fetch_pc`: address of the current or outstanding request.
  - `redirect_pc`
  - `hold_instr`, `hold_pc4`
  - `state`: one of FETCH, HOLD, KILL, ERR.
- **Handshake**
  - `imem_req`=1 only in FETCH and KILL.
  - `imem_addr` = `fetch_pc`, and holds stable until a cycle with `imem_req && imem_ready`.
  - Requests are never withdrawn.
- **Outputs when there is no valid instruction:** `instruction_out`=0, `pc_next_out`=0, `fetch_valid`=0.
- **FETCH**
  - `imem_ready`=1, `stall`=0, `pc_src`=0:
    - Present `imem_rdata` and `fetch_pc+4` combinationally, `fetch_valid`=1.
    - `fetch_pc` <= `fetch_pc+4`.
  - `imem_ready`=1, `stall`=1:
    - Capture `rdata` and pc+4 into the hold registers.
    - `fetch_pc` <= `fetch_pc+4`.
    - Go to HOLD. Outputs are NOP this cycle.
  - `imem_ready`=0: NOP output, remain in FETCH.
- **HOLD**
  - `imem_req`=0. Present the hold registers with `fetch_valid`=1.
  - When `stall`=0, the instruction is consumed at the edge; go to FETCH.
- **Redirect** (`pc_src`=1) has the highest priority in every state except ERR:
  - Outputs are NOP that cycle and any captured or arriving instruction is discarded.
  - In FETCH with `imem_ready`=1, or in HOLD: `fetch_pc` <= `pc_target`, go to FETCH.
  - In FETCH with `imem_ready`=0: `redirect_pc` <= `pc_target`, go to KILL.
  - In KILL: `redirect_pc` <= `pc_target`; the latest target wins.
- **KILL**
  - The old request stays asserted at its old address.
  - On `imem_ready`=1, discard the data, set `fetch_pc` <= `redirect_pc`, go to FETCH.
- **`stall` and `pc_src` together:** redirect wins.
- **Arithmetic:** PC+4 is 32-bit modulo. `32'hFFFF_FFFC` + 4 wraps to 0 with no flag.

## Timing
- **Reset** (async assert, no clock needed):
  - `fetch_pc`=`RESET_PC`, `state`=FETCH, hold registers = 0, `misalign_err`=0.
  - Outputs while `reset_n`=0: `imem_req`=0, `instruction_out`=0, `pc_next_out`=0, `fetch_valid`=0.
  - `imem_req` rises combinationally once `reset_n`=1.
- **Zero-wait memory** (`imem_ready` tied 1): one instruction per cycle. Fetch-to-IF/ID latency is 0 cycles; IF/ID captures at the same edge that advances `fetch_pc`.
- **Wait states:** N wait cycles insert N NOPs.
- **Redirect penalty:**
  - 1 NOP cycle when `imem_ready`=1 in the redirect cycle.
  - Otherwise the remaining wait cycles of the killed request plus 1.
  - First instruction from the target is presented the cycle after `fetch_pc` loads it.
- **Reset mid-operation:** the outstanding request is abandoned and memory must tolerate request drop on reset. The next request after reset release is to `RESET_PC`.

## Configuration
- **`IF_MISALIGN_TRAP_EN` defined:**
  - A redirect with `pc_target[1:0]` != 0 sets `misalign_err`=1 (sticky until reset) and enters ERR.
  - ERR: `imem_req`=0, NOP outputs, all inputs ignored until reset.
  - A KILL already in progress completes its handshake before entering ERR.
- **`IF_MISALIGN_TRAP_EN` undefined:** `pc_target[1:0]` is forced to 0, `misalign_err` is tied 0, and ERR is unreachable.

## Test plan
- **Reset and streaming:** reset with `RESET_PC`=`32'h100`, `imem_ready`=1 → addresses 0x100, 0x104, 0x108 on consecutive cycles; `pc_next_out` 0x104, 0x108, 0x10C; `fetch_valid`=1 from the first cycle.
- **Stall capture:** `stall`=1 for 3 cycles in the cycle word 0x104 returns → `imem_req`=0 during HOLD; `instruction_out` holds that word for 3 cycles; the next request is 0x108 after `stall` drops.
- **Wait states:** `imem_ready` low for 2 cycles on 0x108 → two NOP cycles with `imem_addr` stable at 0x108, then the word is presented.
- **Redirect during wait:** `pc_src`=1, target 0x200 while 0x10C is waiting 3 cycles → 0x10C held until ready, data discarded, next `imem_addr`=0x200, no valid output from 0x10C.
- **Redirect and stall together:** `pc_src`=1 and `stall`=1 while in HOLD → hold dropped, `fetch_pc`=target, `fetch_valid`=0 that cycle.
- **Misaligned redirect:** with the macro defined, target 0x202 → `misalign_err`=1, `imem_req`=0 until `reset_n` pulse; without the macro, the fetch goes to 0x200.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem word reads over req/ready,
// and presents one instruction plus its PC+4 per cycle to IF/ID (NOP when none).
// Optional feature macro: IF_MISALIGN_TRAP_EN (trap on misaligned redirect targets).
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_next_out,
   output logic [31:0] instruction_out,
   output logic        fetch_valid,
   output logic        misalign_err
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      KILL  = 2'd2,
      ERR   = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [XLEN-1:0]   fetch_pc, fetch_pc_nxt;
   logic [XLEN-1:0]   redirect_pc, redirect_pc_nxt;
   logic [XLEN-1:0]   hold_instr, hold_instr_nxt;
   logic [XLEN-1:0]   hold_pc4, hold_pc4_nxt;
   logic              err_q, err_nxt;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   tgt;
   logic              tgt_bad;

   // Redirect target conditioning: trap on misalignment, or silently align.
`ifdef IF_MISALIGN_TRAP_EN
   assign tgt          = pc_target;
   assign tgt_bad      = |pc_target[1:0];
   assign misalign_err = err_q;
`else
   assign tgt          = pc_target & ~XLEN'(3);
   assign tgt_bad      = 1'b0;
   assign misalign_err = 1'b0;
`endif

   assign pc_plus4  = fetch_pc + XLEN'(4);
   assign imem_addr = fetch_pc;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         redirect_pc <= '0;
         hold_instr  <= '0;
         hold_pc4    <= '0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         redirect_pc <= redirect_pc_nxt;
         hold_instr  <= hold_instr_nxt;
         hold_pc4    <= hold_pc4_nxt;
         err_q       <= err_nxt;
      end
   end

   // Next-state and output decode; redirect outranks stall and delivery.
   always_comb begin
      state_nxt       = state;
      fetch_pc_nxt    = fetch_pc;
      redirect_pc_nxt = redirect_pc;
      hold_instr_nxt  = hold_instr;
      hold_pc4_nxt    = hold_pc4;
      err_nxt         = err_q;
      imem_req        = 1'b0;
      instruction_out = '0;
      pc_next_out     = '0;
      fetch_valid     = 1'b0;

      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (pc_src) begin
               if (tgt_bad) err_nxt = 1'b1;
               if (imem_ready) begin
                  if (tgt_bad) begin
                     state_nxt = ERR;
                  end else begin
                     fetch_pc_nxt = tgt;
                  end
               end else begin
                  redirect_pc_nxt = tgt;
                  state_nxt       = KILL;
               end
            end else if (imem_ready) begin
               fetch_pc_nxt = pc_plus4;
               if (stall) begin
                  hold_instr_nxt = imem_rdata;
                  hold_pc4_nxt   = pc_plus4;
                  state_nxt      = HOLD;
               end else begin
                  instruction_out = imem_rdata;
                  pc_next_out     = pc_plus4;
                  fetch_valid     = 1'b1;
               end
            end
         end
         HOLD: begin
            if (pc_src) begin
               if (tgt_bad) begin
                  err_nxt   = 1'b1;
                  state_nxt = ERR;
               end else begin
                  fetch_pc_nxt = tgt;
                  state_nxt    = FETCH;
               end
            end else begin
               instruction_out = hold_instr;
               pc_next_out     = hold_pc4;
               fetch_valid     = 1'b1;
               if (!stall) state_nxt = FETCH;
            end
         end
         KILL: begin
            // Old request stays up at its old address until memory answers.
            imem_req = 1'b1;
            if (pc_src) begin
               redirect_pc_nxt = tgt;
               if (tgt_bad) err_nxt = 1'b1;
            end
            if (imem_ready) begin
               if (err_nxt) begin
                  state_nxt = ERR;
               end else begin
                  fetch_pc_nxt = pc_src ? tgt : redirect_pc;
                  state_nxt    = FETCH;
               end
            end
         end
         default: begin
            state_nxt = ERR;
         end
      endcase

      if (!reset_n) begin
         imem_req        = 1'b0;
         instruction_out = '0;
         pc_next_out     = '0;
         fetch_valid     = 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vectors with literal
// expectations plus a queue-based behavioural model checked every cycle.
module tb_instr_fetch_stage;

   localparam logic [31:0] RST = 32'h0000_0100;
`ifdef IF_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        pc_src;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_next_out;
   logic [31:0] instruction_out;
   logic        fetch_valid;
   logic        misalign_err;

   int total = 0;
   int bad   = 0;

   instr_fetch_stage #(.RESET_PC(RST)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .stall           (stall),
      .pc_src          (pc_src),
      .pc_target       (pc_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .pc_next_out     (pc_next_out),
      .instruction_out (instruction_out),
      .fetch_valid     (fetch_valid),
      .misalign_err    (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h1300_0000 | a;
   endfunction

   function automatic logic is_bad(input logic [31:0] a);
      return TRAP && (a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] eff(input logic [31:0] a);
      return TRAP ? a : (a & ~32'h3);
   endfunction

   // Memory: returns a recognisable word for the requested address when ready.
   assign imem_rdata = imem_ready ? word(imem_addr) : 32'hDEAD_BEEF;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: next address, optional buffered instruction,
   // optional pending redirect behind an unanswered request, error lock.
   logic [31:0] m_addr = RST;
   logic        m_kill = 1'b0;
   logic [31:0] m_ktgt = '0;
   logic        m_err  = 1'b0;
   logic        m_mis  = 1'b0;
   logic [31:0] q_ins[$];
   logic [31:0] q_pc4[$];
   logic        e_req, e_val, bd;
   logic [31:0] e_ins, e_pc4, t;

   // Compare outputs mid-cycle against the model, then advance the model.
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_req", 32'(imem_req), 32'd0);
         chk("rst_valid", 32'(fetch_valid), 32'd0);
         chk("rst_instr", instruction_out, 32'd0);
         chk("rst_pc4", pc_next_out, 32'd0);
         chk("rst_mis", 32'(misalign_err), 32'd0);
         m_addr = RST; m_kill = 1'b0; m_err = 1'b0; m_mis = 1'b0;
         q_ins.delete(); q_pc4.delete();
      end else begin
         t  = eff(pc_target);
         bd = is_bad(pc_target);
         e_req = 1'b0; e_val = 1'b0; e_ins = '0; e_pc4 = '0;
         if (m_err) begin
            e_req = 1'b0;
         end else if (q_ins.size() != 0) begin
            if (!pc_src) begin
               e_val = 1'b1; e_ins = q_ins[0]; e_pc4 = q_pc4[0];
            end
         end else begin
            e_req = 1'b1;
            if (imem_ready && !pc_src && !m_kill && !stall) begin
               e_val = 1'b1; e_ins = word(m_addr); e_pc4 = m_addr + 32'd4;
            end
         end
         chk("m_req", 32'(imem_req), 32'(e_req));
         chk("m_valid", 32'(fetch_valid), 32'(e_val));
         chk("m_instr", instruction_out, e_ins);
         chk("m_pc4", pc_next_out, e_pc4);
         chk("m_mis", 32'(misalign_err), 32'(m_mis));
         if (e_req) chk("m_addr", imem_addr, m_addr);

         if (m_err) begin
            m_err = 1'b1;
         end else if (q_ins.size() != 0) begin
            if (pc_src) begin
               q_ins.delete(); q_pc4.delete();
               if (bd) begin m_mis = 1'b1; m_err = 1'b1; end
               else m_addr = t;
            end else if (!stall) begin
               q_ins.delete(); q_pc4.delete();
            end
         end else if (pc_src) begin
            if (bd) m_mis = 1'b1;
            if (imem_ready) begin
               m_kill = 1'b0;
               if (m_mis) m_err = 1'b1;
               else m_addr = t;
            end else begin
               m_kill = 1'b1; m_ktgt = t;
            end
         end else if (m_kill) begin
            if (imem_ready) begin
               m_kill = 1'b0;
               if (m_mis) m_err = 1'b1;
               else m_addr = m_ktgt;
            end
         end else if (imem_ready) begin
            if (stall) begin
               q_ins.push_back(word(m_addr));
               q_pc4.push_back(m_addr + 32'd4);
            end
            m_addr = m_addr + 32'd4;
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge.
   task automatic cyc(input logic s, input logic p, input logic [31:0] tg, input logic r);
      @(posedge clk);
      #1;
      stall = s; pc_src = p; pc_target = tg; imem_ready = r;
   endtask

   // Sample just after the falling edge of the current cycle.
   task automatic mid;
      @(negedge clk);
      #1;
   endtask

   // Asynchronous reset pulse; outputs must be quiet with no clock edge in between.
   task automatic do_reset;
      @(posedge clk);
      #1;
      reset_n = 1'b0; stall = 1'b0; pc_src = 1'b0; pc_target = '0; imem_ready = 1'b1;
      #1;
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_valid", 32'(fetch_valid), 32'd0);
      mid();
      chk("rst_addr", imem_addr, RST);
      imem_ready = 1'b0;
      reset_n    = 1'b1;
      #1;
      chk("rel_req", 32'(imem_req), 32'd1);
   endtask

   initial begin
      logic [31:0] rt;
      reset_n = 1'b0; stall = 1'b0; pc_src = 1'b0; pc_target = '0; imem_ready = 1'b1;
      do_reset();

      // Streaming at zero wait states.
      cyc(0, 0, 0, 1); mid();
      chk("s0_addr", imem_addr, 32'h100);
      chk("s0_instr", instruction_out, 32'h1300_0100);
      chk("s0_pc4", pc_next_out, 32'h104);
      chk("s0_valid", 32'(fetch_valid), 32'd1);
      // Stall in the cycle 0x104 returns, three stall cycles.
      cyc(1, 0, 0, 1); mid();
      chk("st_addr", imem_addr, 32'h104);
      chk("st_nop", 32'(fetch_valid), 32'd0);
      cyc(1, 0, 0, 1); mid();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_instr", instruction_out, 32'h1300_0104);
      chk("hold_pc4", pc_next_out, 32'h108);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1); mid();
      chk("hold3_instr", instruction_out, 32'h1300_0104);
      // Two wait states on 0x108.
      cyc(0, 0, 0, 0); mid();
      chk("w0_addr", imem_addr, 32'h108);
      chk("w0_valid", 32'(fetch_valid), 32'd0);
      cyc(0, 0, 0, 0); mid();
      chk("w1_addr", imem_addr, 32'h108);
      cyc(0, 0, 0, 1); mid();
      chk("w2_instr", instruction_out, 32'h1300_0108);
      chk("w2_valid", 32'(fetch_valid), 32'd1);
      // Redirect to 0x200 while 0x10C waits three cycles.
      cyc(0, 1, 32'h200, 0); mid();
      chk("rk_addr", imem_addr, 32'h10C);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0); mid();
      chk("rk_hold_addr", imem_addr, 32'h10C);
      chk("rk_req", 32'(imem_req), 32'd1);
      cyc(0, 0, 0, 1); mid();
      chk("rk_discard", 32'(fetch_valid), 32'd0);
      cyc(0, 0, 0, 1); mid();
      chk("rk_new_addr", imem_addr, 32'h200);
      chk("rk_new_instr", instruction_out, 32'h1300_0200);
      // Redirect and stall together while holding.
      cyc(1, 0, 0, 1);
      cyc(1, 1, 32'h300, 0); mid();
      chk("rs_valid", 32'(fetch_valid), 32'd0);
      chk("rs_req", 32'(imem_req), 32'd0);
      cyc(0, 0, 0, 1); mid();
      chk("rs_addr", imem_addr, 32'h300);
      chk("rs_valid2", 32'(fetch_valid), 32'd1);
      // Redirect with ready in the same cycle: one NOP.
      cyc(0, 1, 32'h400, 1); mid();
      chk("rr_valid", 32'(fetch_valid), 32'd0);
      cyc(0, 0, 0, 1); mid();
      chk("rr_addr", imem_addr, 32'h400);
      // Two redirects during a kill: latest target wins.
      cyc(0, 1, 32'h500, 0);
      cyc(0, 1, 32'h600, 0); mid();
      chk("rl_addr", imem_addr, 32'h404);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1); mid();
      chk("rl_new_addr", imem_addr, 32'h600);
      // PC wrap.
      cyc(0, 1, 32'hFFFF_FFFC, 1);
      cyc(0, 0, 0, 1); mid();
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc_next_out, 32'h0);
      chk("wrap_valid", 32'(fetch_valid), 32'd1);
      // Misaligned redirect.
      cyc(0, 1, 32'h202, 1); mid();
      chk("ma_addr", imem_addr, 32'h0);
      chk("ma_valid", 32'(fetch_valid), 32'd0);
      cyc(0, 0, 0, 1); mid();
`ifdef IF_MISALIGN_TRAP_EN
      chk("ma_err", 32'(misalign_err), 32'd1);
      chk("ma_req", 32'(imem_req), 32'd0);
      cyc(0, 1, 32'h400, 1); mid();
      chk("ma_req2", 32'(imem_req), 32'd0);
      chk("ma_valid2", 32'(fetch_valid), 32'd0);
`else
      chk("ma_align_addr", imem_addr, 32'h200);
      chk("ma_err0", 32'(misalign_err), 32'd0);
`endif
      // Reset in the middle of a kill.
      cyc(0, 1, 32'h700, 0);
      do_reset();
      cyc(0, 0, 0, 1); mid();
      chk("rr_rst_addr", imem_addr, RST);
      chk("rr_rst_instr", instruction_out, 32'h1300_0100);
      chk("rr_rst_err", 32'(misalign_err), 32'd0);

      // Random traffic checked by the model.
      for (int i = 0; i < 400; i++) begin
         if (i % 60 == 59) begin
            do_reset();
         end else begin
            rt = 32'($urandom_range(0, 4095)) << 2;
            if ($urandom_range(0, 9) == 0) rt = rt | 32'h2;
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), rt,
                ($urandom_range(0, 2) != 0));
         end
      end

      @(negedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
